// File: rtl/rib_arbiter_if.sv
// Bus bundle between the masters, the arbiter and the shared system-bus slave port.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface rib_arbiter_if #(
    parameter int NUM_M = 4
);
    logic [NUM_M-1:0]    m_req_i;
    logic [NUM_M-1:0]    m_we_i;
    logic [NUM_M*32-1:0] m_addr_i;
    logic [NUM_M*32-1:0] m_data_i;
    logic [NUM_M-1:0]    m_ack_o;
    logic [31:0]         m_data_o;
    logic                s_req_o;
    logic                s_we_o;
    logic [31:0]         s_addr_o;
    logic [31:0]         s_data_o;
    logic                s_ack_i;
    logic [31:0]         s_data_i;
    logic [NUM_M-1:0]    grant_o;
    logic                hold_flag_o;
    logic                err_o;

    modport slave (
        input  m_req_i, m_we_i, m_addr_i, m_data_i, s_ack_i, s_data_i,
        output m_ack_o, m_data_o, s_req_o, s_we_o, s_addr_o, s_data_o,
               grant_o, hold_flag_o, err_o
    );

    modport master (
        output m_req_i, m_we_i, m_addr_i, m_data_i, s_ack_i, s_data_i,
        input  m_ack_o, m_data_o, s_req_o, s_we_o, s_addr_o, s_data_o,
               grant_o, hold_flag_o, err_o
    );
endinterface

// File: rtl/rib_arbiter.sv
// Round-robin arbiter sharing one bus slave between NUM_M masters; grant one cycle after request.
// Masters are backpressured by holding req until ack; dropped request aborts, stalled slave times out.
module rib_arbiter #(
    parameter int NUM_M   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    rib_arbiter_if.slave bus
);
    localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]       state;
    logic [NUM_M-1:0] grant;
    logic [IW-1:0]    last;
    logic [15:0]      tcnt;
    logic             err;

    logic             busy;
    logic [NUM_M-1:0] sel_oh;
    logic [IW-1:0]    g_idx;
    logic             g_req;
    logic             g_we;
    logic [31:0]      g_addr;
    logic [31:0]      g_data;
    logic             ack;
    logic             abort;
    logic             tmo;

    assign busy = (state == BUSY);

    // Scan last+1, last+2, ... modulo NUM_M; first requester wins.
    always_comb begin
        logic found;
        int   idx;
        sel_oh = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 1; i <= NUM_M; i++) begin
            idx = (int'(last) + i) % NUM_M;
            if (!found && bus.m_req_i[idx]) begin
                sel_oh[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    // Grant is zero outside BUSY, so the muxed master fields fall to zero there too.
    always_comb begin
        g_idx  = '0;
        g_req  = 1'b0;
        g_we   = 1'b0;
        g_addr = '0;
        g_data = '0;
        for (int k = 0; k < NUM_M; k++) begin
            if (grant[k]) begin
                g_idx  = IW'(k);
                g_req  = bus.m_req_i[k];
                g_we   = bus.m_we_i[k];
                g_addr = bus.m_addr_i[32*k +: 32];
                g_data = bus.m_data_i[32*k +: 32];
            end
        end
    end

    assign ack   = busy & bus.s_ack_i;
    assign abort = busy & ~bus.s_ack_i & ~g_req;
    assign tmo   = busy & ~bus.s_ack_i & (tcnt == 16'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            last  <= IW'(NUM_M - 1);
            tcnt  <= '0;
            err   <= 1'b0;
        end else begin
            err <= 1'b0;
            if (state == IDLE) begin
                if (|bus.m_req_i) begin
                    state <= BUSY;
                    grant <= sel_oh;
                    tcnt  <= '0;
                end
            end else begin
                if (ack || abort || tmo) begin
                    state <= IDLE;
                    grant <= '0;
                    last  <= g_idx;
                    err   <= tmo;
                end else begin
                    tcnt <= tcnt + 16'd1;
                end
            end
        end
    end

    assign bus.grant_o     = grant;
    assign bus.err_o       = err;
    assign bus.s_req_o     = busy;
    assign bus.s_we_o      = busy & g_we;
    assign bus.s_addr_o    = busy ? g_addr : 32'h0;
    assign bus.s_data_o    = busy ? g_data : 32'h0;
    assign bus.m_ack_o     = ack ? grant : '0;
    assign bus.m_data_o    = ack ? bus.s_data_i : 32'h0;
    // The core stalls up to and excluding the cycle its own ack arrives.
    assign bus.hold_flag_o = bus.m_req_i[0] & ~(ack & grant[0]);
endmodule

// File: doc/rib_arbiter.md
# rib_arbiter

Round-robin arbiter that shares the single system bus slave port between up to NUM_M bus masters (core data port, core fetch, JTAG debug, DMA). Master 0 is the core. The block holds one grant per transaction and times out stalled slaves. It raises a one-bit hold request to `ctrl` whenever the core is waiting on the bus.

## Interface
- NUM_M, 4: number of masters (2..8)
- TIMEOUT, 255: max BUSY cycles before forced abort (1..65535)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- m_req_i  in  NUM_M  per-master request, held until m_ack_o or abort
- m_we_i  in  NUM_M  per-master write enable
- m_addr_i  in  NUM_M*32  per-master address, master k at bits [32k+31:32k]
- m_data_i  in  NUM_M*32  per-master write data, same packing
- m_ack_o  out  NUM_M  per-master completion strobe
- m_data_o  out  32  read data, broadcast to all masters
- s_req_o  out  1  slave request
- s_we_o  out  1  slave write enable
- s_addr_o  out  32  slave address
- s_data_o  out  32  slave write data
- s_ack_i  in  1  slave completion, single-cycle
- s_data_i  in  32  slave read data, valid with s_ack_i
- grant_o  out  NUM_M  one-hot registered grant, 0 when idle
- hold_flag_o  out  1  to ctrl hold input, 1 = HoldEnable
- err_o  out  1  one-cycle timeout pulse

## Operation
- State machine has two states, IDLE and BUSY. Reset values:
  - state = IDLE, grant_o = 0, last pointer = NUM_M-1, timeout counter = 0, err_o = 0.
- **IDLE**
  - If any m_req_i bit is set, select the first requester scanning last+1, last+2, … modulo NUM_M.
  - Register the one-hot grant and go to BUSY.
  - If no requests, stay in IDLE with grant_o = 0.
- **BUSY**
  - s_req_o = 1.
  - s_we_o, s_addr_o and s_data_o are muxed from the granted master. They are 0 outside BUSY.
- **Completion:** in BUSY with s_ack_i = 1:
  - m_ack_o[g] = 1, combinational, same cycle.
  - m_data_o = s_data_i; it is 0 when s_ack_i = 0.
  - Next cycle: state = IDLE, last = g, grant_o = 0.
- **Abort:** if m_req_i[g] drops while BUSY and s_ack_i = 0:
  - Go to IDLE next cycle with no ack and last = g.
  - The slave sees s_req_o fall.
- **Timeout:** the counter is cleared on entry to BUSY and increments each BUSY cycle without s_ack_i. When it reaches TIMEOUT-1 and there is no ack:
  - err_o pulses next cycle.
  - state = IDLE, last = g, no m_ack_o.
  - The master must drop or re-raise its request.
- **Ack vs. abort/timeout:** if s_ack_i arrives in the same cycle, completion wins.
- **hold_flag_o** = m_req_i[0] & ~(BUSY & grant_o[0] & s_ack_i). It is combinational, so the core stalls until the cycle its ack arrives.
- **Ack/request protocol:**
  - m_ack_o is never asserted to a non-granted master.
  - s_ack_i in IDLE is ignored.
- **Asynchronous reset** mid-BUSY: all outputs go to reset values immediately and no ack is produced.

## Timing
- Request at cycle n with the arbiter in IDLE: grant_o and s_req_o assert at n+1.
- Zero-wait slave (s_ack_i at n+1): m_ack_o at n+1, arbiter back in IDLE at n+2.
- Minimum spacing is 2 cycles per transaction, because every transaction passes through IDLE.
- Fairness: a continuously requesting master waits at most (NUM_M-1) transactions plus its own.
- Worst-case slot is TIMEOUT BUSY cycles.
- grant_o, state and err_o are registered. m_ack_o, m_data_o, s_* outputs and hold_flag_o are combinational from state and inputs.

## Test plan
- **Single request:** m_req_i = 0001, read addr 0x1000_0000, slave acks 2 cycles after s_req_o with 0xDEADBEEF.
  - grant_o = 0001 at n+1; m_ack_o[0] and m_data_o = 0xDEADBEEF at n+3; hold_flag_o high n..n+2 and low at n+3.
- **Round-robin:** m_req_i = 1111 held, zero-wait slave.
  - Grant sequence 0001, 0010, 0100, 1000, 0001, each grant 2 cycles apart.
  - s_addr_o tracks the granted master each BUSY cycle.
- **Timeout:** TIMEOUT = 4, master 2 requests, slave never acks.
  - 4 BUSY cycles, then err_o pulses once, no m_ack_o, IDLE.
  - Next grant goes to master 3 if it is requesting.
- **Abort:** master 1 granted, m_req_i[1] dropped on the second BUSY cycle with no ack.
  - IDLE next cycle, s_req_o low, m_ack_o = 0.
- **Reset mid-op:** rst pulsed during BUSY.
  - grant_o = 0, s_req_o = 0 and err_o = 0 immediately.
  - After release, master 0 wins first when all masters request.
- **Simultaneous events:** s_ack_i and the timeout-limit cycle coincide.
  - Normal ack delivered and err_o stays 0.
  - s_ack_i asserted in IDLE is ignored.
